// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants for the LFSR generator.
// Segment codes, default tap masks and the digit-count helper.
package lfsr_pkg;

  localparam logic [6:0] SEG7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [3:0]  TAPS4  = 4'h3;
  localparam logic [7:0]  TAPS8  = 8'h1D;
  localparam logic [15:0] TAPS16 = 16'h002D;
  localparam logic [31:0] TAPS32 = 32'h00000057;

  function automatic int lfsr_digits(input int width);
    return width / 4;
  endfunction

endpackage

// File: rtl/lfsr_gen_seg7.sv
// lfsr_gen_seg7: one hex digit to active-low gfedcba segments.
// Pure lookup, no state.
module lfsr_gen_seg7
  import lfsr_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // table lookup of the active-low pattern
  always_comb begin
    seg = SEG7[nib];
  end

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with seed load, lock-up repair and 7-seg.
// Define LFSR_PERIOD_EN to add the period/period_valid measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(8'h1D)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] data_out,
  output logic             zero_fix,
`ifdef LFSR_PERIOD_EN
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
`endif
  output logic [7*lfsr_digits(WIDTH)-1:0] seg
);

  localparam int DIGITS = lfsr_digits(WIDTH);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] nxt;
  logic             fb;
  logic             adv;
  logic             lock;

  // feedback parity and shifted next state
  always_comb begin
    fb   = ^(state & TAPS);
    nxt  = {fb, state[WIDTH-1:1]};
    adv  = en | step;
    lock = (state == '0);
  end

  // state register: rst > load > zero repair > advance > hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= '0;
      zero_fix <= 1'b0;
    end else if (load) begin
      state    <= seed;
      zero_fix <= 1'b0;
    end else if (lock) begin
      state    <= WIDTH'(1);
      zero_fix <= 1'b1;
    end else begin
      zero_fix <= 1'b0;
      if (adv) state <= nxt;
    end
  end

  assign data_out = state;

`ifdef LFSR_PERIOD_EN
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] ref_state;

  // lap counter: re-arms on any new start state
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      ref_state    <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (load) begin
      ref_state    <= seed;
      count        <= '0;
      period_valid <= 1'b0;
    end else if (lock) begin
      ref_state    <= WIDTH'(1);
      count        <= '0;
      period_valid <= 1'b0;
    end else if (adv) begin
      if (nxt == ref_state) begin
        period       <= count + 1'b1;
        period_valid <= 1'b1;
        count        <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end
`endif

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    lfsr_gen_seg7 u_seg (
      .nib (state[4*d +: 4]),
      .seg (seg[7*d +: 7])
    );
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: random and directed checks against a reference model.
// Period checks are compiled in only with LFSR_PERIOD_EN.
module tb_lfsr_gen;
  import lfsr_pkg::*;

  localparam int W = 8;
  localparam int D = W / 4;

  logic         clk = 1'b0;
  logic         rst, en, step, load;
  logic [W-1:0] seed;
  logic [W-1:0] data_out;
  logic         zero_fix;
  logic [7*D-1:0] seg;
`ifdef LFSR_PERIOD_EN
  logic [W-1:0] period;
  logic         period_valid;
`endif

  always #5 clk = ~clk;

  lfsr_gen #(.WIDTH(W), .TAPS(8'h1D)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .step     (step),
    .load     (load),
    .seed     (seed),
    .data_out (data_out),
    .zero_fix (zero_fix),
`ifdef LFSR_PERIOD_EN
    .period       (period),
    .period_valid (period_valid),
`endif
    .seg      (seg)
  );

  int n_tests = 0;
  int n_fail  = 0;

  bit [6:0] hex_tab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // model state
  int m_s, m_zf, m_cnt, m_ref, m_per, m_pv;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int adv(input int s, input int w,
                             input logic [31:0] mask);
    int p;
    p = $countones(32'(s) & mask) % 2;
    return (s >> 1) | (p << (w - 1));
  endfunction

  function automatic int period_of(input int w,
                                   input logic [31:0] mask);
    int s, n;
    s = 1;
    n = 0;
    do begin
      s = adv(s, w, mask);
      n++;
    end while (s != 1 && n < (1 << w) + 2);
    return n;
  endfunction

  function automatic logic [7*D-1:0] seg_of(input int s);
    logic [7*D-1:0] r;
    r = '0;
    for (int d = 0; d < D; d++)
      r[7*d +: 7] = hex_tab[(s >> (4*d)) & 15];
    return r;
  endfunction

  task automatic model();
    int n;
    if (rst) begin
      m_s = 0; m_zf = 0; m_cnt = 0;
      m_ref = 0; m_per = 0; m_pv = 0;
    end else if (load) begin
      m_s = int'(seed); m_zf = 0;
      m_ref = m_s; m_cnt = 0; m_pv = 0;
    end else if (m_s == 0) begin
      m_s = 1; m_zf = 1;
      m_ref = 1; m_cnt = 0; m_pv = 0;
    end else begin
      m_zf = 0;
      if (en || step) begin
        n = adv(m_s, W, 32'h1D);
        if (n == m_ref) begin
          m_per = (m_cnt + 1) % (1 << W);
          m_pv = 1;
          m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1) % (1 << W);
        end
        m_s = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    check("data", 64'(data_out), 64'(m_s));
    check("zfix", 64'(zero_fix), 64'(m_zf));
    check("seg", 64'(seg), 64'(seg_of(m_s)));
`ifdef LFSR_PERIOD_EN
    check("pval", 64'(period_valid), 64'(m_pv));
    check("per", 64'(period), 64'(m_per));
`endif
  endtask

  initial begin
    int exp_seq [6] = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h88};
    int laps;

    rst = 1; en = 0; step = 0; load = 0; seed = '0;
    #1;

    check("max4", 64'(period_of(4, 32'(TAPS4))), 64'd15);
    check("max8", 64'(period_of(8, 32'(TAPS8))), 64'd255);
    check("max16", 64'(period_of(16, 32'(TAPS16))), 64'd65535);

    tick();
    check("rst_data", 64'(data_out), 64'h00);
    check("rst_zf", 64'(zero_fix), 64'h0);

    rst = 0; en = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("seq", 64'(data_out), 64'(exp_seq[i]));
      check("seq_zf", 64'(zero_fix), (i == 0) ? 64'd1 : 64'd0);
    end
    check("seg88", 64'(seg[13:0]), 64'h0000);

    load = 1; seed = 8'h10;
    tick();
    check("ld_wins", 64'(data_out), 64'h10);
    load = 0;
    tick();
    check("ld_next", 64'(data_out), 64'h88);

    en = 0;
    for (int i = 0; i < 4; i++) begin
      step = 1;
      tick();
      step = 0;
      tick();
      tick();
    end

    rst = 1;
    tick();
    rst = 0;
    tick();
    check("idle_fix", 64'(data_out), 64'h01);
    tick();
    tick();
    check("idle_hold", 64'(data_out), 64'h01);

    load = 1; seed = 8'h00;
    tick();
    check("ld0", 64'(data_out), 64'h00);
    load = 0;
    tick();
    check("ld0_fix", 64'(data_out), 64'h01);
    check("ld0_zf", 64'(zero_fix), 64'h1);
    tick();
    check("ld0_zf_end", 64'(zero_fix), 64'h0);

    load = 1; seed = 8'h01;
    tick();
    load = 0; en = 1;
    laps = 0;
`ifdef LFSR_PERIOD_EN
    for (int k = 1; k <= 300 && laps == 0; k++) begin
      tick();
      if (period_valid) laps = k;
    end
    check("lap_cyc", 64'(laps), 64'd255);
    check("lap_per", 64'(period), 64'd255);
    for (int k = 0; k < 20; k++) tick();
    load = 1; seed = 8'h5A;
    tick();
    load = 0;
    check("ld_clr_pv", 64'(period_valid), 64'h0);
    check("ld_hold_per", 64'(period), 64'd255);
`else
    for (int k = 0; k < 40; k++) tick();
`endif

    rst = 1;
    tick();
    check("mid_rst", 64'(data_out), 64'h00);
    check("mid_rst_zf", 64'(zero_fix), 64'h0);
`ifdef LFSR_PERIOD_EN
    check("mid_rst_pv", 64'(period_valid), 64'h0);
`endif
    rst = 0;
    tick();
    check("mid_rst_fix", 64'(data_out), 64'h01);

    for (int k = 0; k < 3000; k++) begin
      rst  = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 15) == 0);
      seed = W'($urandom);
      en   = ($urandom_range(0, 3) != 0);
      step = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
